// File: rtl/v68k_alu_pkg.sv
// Shared encodings for the v68k multiply/divide unit.
// Op codes and sequencer state enum.
package v68k_alu_pkg;

    localparam logic [1:0] OP_MULU = 2'd0;
    localparam logic [1:0] OP_MULS = 2'd1;
    localparam logic [1:0] OP_DIVU = 2'd2;
    localparam logic [1:0] OP_DIVS = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 sequential MULU/MULS/DIVU/DIVS for the v68k execution stage.
// One shared accumulator; 68000-style results and NZVC flags.
module muldiv_unit
    import v68k_alu_pkg::*;
#(
    parameter int bits = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [bits-1:0]   a,
    input  logic [2*bits-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [2*bits-1:0] result,
    output logic              c,
    output logic              z,
    output logic              v,
    output logic              n,
    output logic              div_zero
);

    localparam int CW = $clog2(bits + 1);
    localparam logic [bits-1:0] QLIM = {1'b1, {(bits-1){1'b0}}};

    state_t state, state_nx;

    logic [1:0]        op_q;
    logic [bits-1:0]   a_q;
    logic [2*bits-1:0] b_q;
    logic [2*bits:0]   acc;
    logic [CW-1:0]     cnt;
    logic [bits-1:0]   dvs;
    logic              neg_q, neg_r, big, ovf_q;

    logic is_div, is_sgn;
    assign is_div = op_q[1];
    assign is_sgn = op_q[0];

    logic [bits-1:0]   mag_a, mag_m;
    logic [2*bits-1:0] mag_d;
    logic              skip_now;

    always_comb begin
        mag_a = (is_sgn && a_q[bits-1]) ? -a_q : a_q;
        mag_m = (is_sgn && b_q[bits-1]) ? -b_q[bits-1:0] : b_q[bits-1:0];
        mag_d = (is_sgn && b_q[2*bits-1]) ? -b_q : b_q;
        skip_now = is_div && ((a_q == '0) ||
                   (op_q == OP_DIVU && b_q[2*bits-1:bits] >= a_q));
    end

    logic [bits:0]   msum, trial;
    logic [2*bits:0] mul_nx, sh, div_nx;

    always_comb begin
        msum   = {1'b0, acc[2*bits-1:bits]} + {1'b0, dvs};
        mul_nx = acc[0] ? {1'b0, msum, acc[bits-1:1]} : {1'b0, acc[2*bits:1]};
        sh     = {acc[2*bits-1:0], 1'b0};
        trial  = sh[2*bits:bits] - {1'b0, dvs};
        div_nx = (sh[2*bits:bits] >= {1'b0, dvs}) ?
                 {trial, sh[bits-1:1], 1'b1} : sh;
    end

    logic [2*bits-1:0] mres;
    logic [bits-1:0]   quo, rem, quo_m, rem_m;
    logic              late_ovf;

    always_comb begin
        quo_m = acc[bits-1:0];
        rem_m = acc[2*bits-1:bits];
        mres  = neg_q ? -acc[2*bits-1:0] : acc[2*bits-1:0];
        quo   = neg_q ? -quo_m : quo_m;
        rem   = neg_r ? -rem_m : rem_m;
        // Negative quotients may reach magnitude 2^(bits-1), positives may not.
        late_ovf = is_div && is_sgn &&
                   (big || (neg_q ? (quo_m > QLIM) : quo_m[bits-1]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = PREP;
            PREP: state_nx = skip_now ? FIX : ITER;
            ITER: if (cnt == CW'(bits - 1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign c    = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            big      <= 1'b0;
            ovf_q    <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            z        <= 1'b0;
            v        <= 1'b0;
            n        <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    op_q     <= op;
                    a_q      <= a;
                    b_q      <= b;
                    div_zero <= 1'b0;
                end
                PREP: begin
                    dvs   <= is_div ? mag_a : mag_a;
                    neg_q <= is_sgn &&
                             (a_q[bits-1] ^ (is_div ? b_q[2*bits-1] : b_q[bits-1]));
                    neg_r <= is_sgn && is_div && b_q[2*bits-1];
                    big   <= mag_d[2*bits-1:bits] >= mag_a;
                    cnt   <= '0;
                    ovf_q <= skip_now && (a_q != '0);
                    acc   <= is_div ? {1'b0, mag_d} : {1'b0, {bits{1'b0}}, mag_m};
                    if (is_div && a_q == '0) div_zero <= 1'b1;
                end
                ITER: begin
                    acc <= is_div ? div_nx : mul_nx;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (div_zero) begin
                        result <= b_q;
                        n <= 1'b0; z <= 1'b0; v <= 1'b0;
                    end else if (ovf_q || late_ovf) begin
                        result <= b_q;
                        n <= 1'b0; z <= 1'b0; v <= 1'b1;
                    end else if (is_div) begin
                        result <= {rem, quo};
                        n <= quo[bits-1];
                        z <= (quo == '0);
                        v <= 1'b0;
                    end else begin
                        result <= mres;
                        n <= mres[2*bits-1];
                        z <= (mres == '0);
                        v <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table vectors, corner sequences,
// and random ops against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, c, z, v, n, div_zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.bits(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .c(c), .z(z), .v(v), .n(n), .div_zero(div_zero)
    );

    typedef struct {
        logic [31:0] res;
        bit          n, z, v, dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    function automatic exp_t model(logic [1:0] mop, logic [15:0] ma, logic [31:0] mb);
        exp_t   e;
        longint p, q, r, dd, ds;
        e = '{res: '0, n: 0, z: 0, v: 0, dz: 0, lat: 18};
        if (mop == 2'd0 || mop == 2'd1) begin
            if (mop == 2'd0) p = longint'(ma) * longint'(mb[15:0]);
            else p = longint'($signed(ma)) * longint'($signed(mb[15:0]));
            e.res = p[31:0];
            e.n = e.res[31];
            e.z = (e.res == 0);
        end else if (ma == 0) begin
            e.res = mb; e.dz = 1; e.lat = 2;
        end else begin
            if (mop == 2'd2) begin
                dd = longint'(mb); ds = longint'(ma);
            end else begin
                dd = longint'($signed(mb)); ds = longint'($signed(ma));
            end
            q = dd / ds;
            r = dd % ds;
            if (mop == 2'd2 && q > 65535) begin
                e.res = mb; e.v = 1; e.lat = 2;
            end else if (mop == 2'd3 && (q > 32767 || q < -32768)) begin
                e.res = mb; e.v = 1;
            end else begin
                e.res = {r[15:0], q[15:0]};
                e.n = q[15];
                e.z = (q[15:0] == 0);
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(logic [1:0] lop, logic [15:0] la, logic [31:0] lb);
        op = lop; a = la; b = lb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!done && lat < 100);
        if (!done) chk("done timeout", 32'(done), 32'd1);
    endtask

    task automatic check_out(string nm, exp_t e, int lat);
        chk({nm, " result"}, result, e.res);
        chk({nm, " n"}, 32'(n), 32'(e.n));
        chk({nm, " z"}, 32'(z), 32'(e.z));
        chk({nm, " v"}, 32'(v), 32'(e.v));
        chk({nm, " c"}, 32'(c), 32'd0);
        chk({nm, " div_zero"}, 32'(div_zero), 32'(e.dz));
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " latency"}, 32'(lat), 32'(e.lat));
    endtask

    vec_t tbl[8];

    initial begin
        int   lat, lat2, seen;
        exp_t e;
        logic [1:0]  rop;
        logic [15:0] ra;
        logic [31:0] rb;

        tbl[0] = '{2'd0, 16'hFFFF, 32'h0000FFFF, '{32'hFFFE0001, 1, 0, 0, 0, 18}};
        tbl[1] = '{2'd1, 16'hFFFF, 32'h00000002, '{32'hFFFFFFFE, 1, 0, 0, 0, 18}};
        tbl[2] = '{2'd0, 16'h0000, 32'h00001234, '{32'h00000000, 0, 1, 0, 0, 18}};
        tbl[3] = '{2'd2, 16'h0002, 32'h00010001, '{32'h00018000, 1, 0, 0, 0, 18}};
        tbl[4] = '{2'd3, 16'h0002, 32'hFFFFFFF9, '{32'hFFFFFFFD, 1, 0, 0, 0, 18}};
        tbl[5] = '{2'd2, 16'h0002, 32'h00020000, '{32'h00020000, 0, 0, 1, 0, 2}};
        tbl[6] = '{2'd3, 16'h0001, 32'h00008000, '{32'h00008000, 0, 0, 1, 0, 18}};
        tbl[7] = '{2'd2, 16'h0000, 32'h12345678, '{32'h12345678, 0, 0, 0, 1, 2}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset result", result, 0);
        chk("reset flags", {28'd0, n, z, v, c}, 0);
        chk("reset div_zero", 32'(div_zero), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            launch(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d busy", i), 32'(busy), 1);
            wait_done(lat);
            check_out($sformatf("vec%0d", i), tbl[i].e, lat);
        end

        // div_zero holds while idle, then clears on the next accepted start
        repeat (2) @(posedge clk);
        #1 chk("dz hold", 32'(div_zero), 1);
        launch(2'd0, 16'd3, 32'd4);
        chk("dz clear on start", 32'(div_zero), 0);
        wait_done(lat);
        check_out("after dz", model(2'd0, 16'd3, 32'd4), lat);

        // start while busy is ignored
        launch(2'd0, 16'd3, 32'd5);
        repeat (3) @(posedge clk);
        #1 op = 2'd2; a = 16'd0; b = 32'h7777; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check_out("ignored start", model(2'd0, 16'd3, 32'd5), lat + 4);

        // reset during iteration 5
        launch(2'd0, 16'hFFFF, 32'h0000FFFF);
        repeat (6) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst result", result, 0);
        chk("midrst flags", {27'd0, done, n, z, v, c}, 0);
        @(negedge clk) reset_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1 if (done) seen = 1;
        end
        chk("no done after reset", 32'(seen), 0);

        // back-to-back start in the done cycle
        launch(2'd1, 16'h8000, 32'h00008000);
        wait_done(lat);
        check_out("b2b first", model(2'd1, 16'h8000, 32'h00008000), lat);
        launch(2'd3, 16'hFFFD, 32'h00001000);
        chk("done one cycle", 32'(done), 0);
        chk("b2b busy", 32'(busy), 1);
        wait_done(lat2);
        check_out("b2b second", model(2'd3, 16'hFFFD, 32'h00001000), lat2);

        for (int i = 0; i < 300; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = $urandom;
            if ($urandom_range(0, 15) == 0) ra = 16'd0;
            if (rop == 2'd2 && ra != 0 && $urandom_range(0, 3) != 0)
                rb[31:16] = 16'($urandom % ra);
            if (rop == 2'd3 && $urandom_range(0, 3) != 0)
                rb = {{16{rb[15]}}, rb[15:0]};
            e = model(rop, ra, rb);
            launch(rop, ra, rb);
            wait_done(lat);
            check_out($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), e, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
